// File: rtl/key_cmd_fifo_if.sv
// Keypad command bus: key level/code from the keyboard side, FIFO head and status to the consumer.
// Latency: none, wires only.
// Backpressure: consumer drains with cmd_pop; producer side has none (drops are flagged by overflow).
// Ports: key, key_num (producer -> FIFO); cmd_pop (consumer -> FIFO);
//        cmd_valid, cmd, cmd_count, overflow (FIFO -> consumer).
interface key_cmd_fifo_if;
  logic       key;
  logic [2:0] key_num;
  logic       cmd_pop;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic [2:0] cmd_count;
  logic       overflow;

  // master: the environment driving keys and popping commands
  modport master (
    output key, key_num, cmd_pop,
    input  cmd_valid, cmd, cmd_count, overflow
  );

  // slave: the command FIFO itself
  modport slave (
    input  key, key_num, cmd_pop,
    output cmd_valid, cmd, cmd_count, overflow
  );
endinterface

// File: rtl/key_cmd_fifo.sv
// Turns held-key levels into press + auto-repeat commands queued in a 4-deep FIFO.
// Latency: a press is written on the edge it is seen; cmd_valid rises the next cycle.
// Backpressure: none upstream; pushes into a full FIFO are dropped and set sticky overflow.
// Ports: clk, rst (sync, active-high); bus.key/key_num in, bus.cmd_pop in,
//        bus.cmd_valid/cmd (first-word-fall-through head), bus.cmd_count, bus.overflow out.
module key_cmd_fifo #(
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic          clk,
  input  logic          rst,
  key_cmd_fifo_if.slave bus
);

  localparam logic [31:0] DELAY_LAST  = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] PERIOD_LAST = 32'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  state_t      state;
  logic [31:0] cnt;
  logic        key_q;
  logic [2:0]  num_q;

  logic [2:0]  mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;
  logic        overflow_q;

  logic num_ok;
  logic press;
  logic repeat_due;
  logic push;
  logic pop;
  logic full;

  assign num_ok = (bus.key_num <= 3'd4);
  // Fresh press: key just went down, or the code changed while held.
  assign press  = bus.key && num_ok && (!key_q || (bus.key_num != num_q));

  // Repeat only fires while the same valid code is still held (press wins otherwise).
  assign repeat_due = bus.key && num_ok && !press &&
                      (((state == HOLD) && (bus.key_num != 3'd4) && (cnt == DELAY_LAST)) ||
                       ((state == REPEAT) && (cnt == PERIOD_LAST)));

  // Outside a press the live code equals the held code, so key_num is always the push data.
  assign push = press || repeat_due;
  assign full = (count == 3'd4);
  assign pop  = bus.cmd_pop && (count != 3'd0);

  // Repeat timing FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      key_q <= 1'b0;
      num_q <= '0;
    end else begin
      key_q <= bus.key;
      num_q <= bus.key_num;
      if (bus.key && !num_ok) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (press) begin
              state <= HOLD;
              cnt   <= '0;
            end
          end
          HOLD: begin
            if (!bus.key) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (press) begin
              cnt <= '0;
            end else if (bus.key_num == 3'd4) begin
              cnt <= cnt;  // enter never auto-repeats
            end else if (cnt == DELAY_LAST) begin
              state <= REPEAT;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          REPEAT: begin
            if (!bus.key) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (press) begin
              state <= HOLD;
              cnt   <= '0;
            end else if (cnt == PERIOD_LAST) begin
              cnt <= '0;
            end else begin
              cnt <= cnt + 32'd1;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

  // Command FIFO. When full, a simultaneous pop frees the head slot, which is
  // exactly where wr_ptr points, so the write lands there safely.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push && (!full || pop)) begin
        mem[wr_ptr] <= bus.key_num;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      if (push && full && !pop) begin
        overflow_q <= 1'b1;
      end
      if (push && (!full || pop) && !pop) begin
        count <= count + 3'd1;
      end else if (pop && !push) begin
        count <= count - 3'd1;
      end
    end
  end

  assign bus.cmd_valid = (count != 3'd0);
  assign bus.cmd       = (count != 3'd0) ? mem[rd_ptr] : 3'd0;
  assign bus.cmd_count = count;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_key_cmd_fifo.sv
// Bench for key_cmd_fifo: directed key scenarios then random key/pop/reset traffic,
// every cycle compared against a timestamp-and-queue reference model.
module tb_key_cmd_fifo;
  localparam int D = 8;
  localparam int P = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  key_cmd_fifo_if bus();

  key_cmd_fifo #(.REPEAT_DELAY(D), .REPEAT_PERIOD(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: queue of commands, previous key sample, and the absolute
  // cycle at which the next auto-repeat is due.
  logic [2:0] q[$];
  bit         m_ovf;
  bit         m_pk;
  logic [2:0] m_pn;
  bit         m_active;
  bit         m_rep_en;
  int         m_due;
  int         now = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, now);
    end
  endtask

  task automatic model_step(input bit k, input logic [2:0] n, input bit p, input bit r);
    bit push;
    bit press;
    if (r) begin
      q.delete();
      m_ovf = 0; m_pk = 0; m_pn = 3'd0; m_active = 0; m_rep_en = 0; m_due = 0;
      return;
    end
    push  = 0;
    press = k && (n <= 3'd4) && (!m_pk || (n != m_pn));
    if (k && (n >= 3'd5)) begin
      m_active = 0;
    end else if (press) begin
      push     = 1;
      m_active = 1;
      m_rep_en = (n != 3'd4);
      m_due    = now + D;
    end else if (!k) begin
      m_active = 0;
    end else if (m_active && m_rep_en && (now == m_due)) begin
      push  = 1;
      m_due = now + P;
    end
    if (p && (q.size() > 0)) void'(q.pop_front());
    if (push) begin
      if (q.size() < 4) q.push_back(n);
      else m_ovf = 1;
    end
    m_pk = k;
    m_pn = n;
  endtask

  // One clock: apply inputs, advance model on the edge, compare shortly after.
  task automatic cyc(input bit k, input logic [2:0] n, input bit p, input bit r);
    bus.key     = k;
    bus.key_num = n;
    bus.cmd_pop = p;
    rst         = r;
    @(posedge clk);
    model_step(k, n, p, r);
    now++;
    #1;
    check("cmd_valid", int'(bus.cmd_valid), (q.size() > 0) ? 1 : 0);
    check("cmd",       int'(bus.cmd),       (q.size() > 0) ? int'(q[0]) : 0);
    check("cmd_count", int'(bus.cmd_count), q.size());
    check("overflow",  int'(bus.overflow),  int'(m_ovf));
  endtask

  initial begin
    bit         k;
    logic [2:0] n;
    bus.key = 0; bus.key_num = 0; bus.cmd_pop = 0;

    // Reset state
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    check("rst_valid", int'(bus.cmd_valid), 0);
    check("rst_count", int'(bus.cmd_count), 0);
    check("rst_ovf",   int'(bus.overflow),  0);

    // Single short press, pop, and a pop on empty
    cyc(1, 2, 0, 0);
    check("short_cmd", int'(bus.cmd), 2);
    for (int i = 0; i < 4; i++) cyc(0, 2, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    check("short_pop_count", int'(bus.cmd_count), 0);

    // Long hold with repeats until overflow
    cyc(0, 0, 0, 1);
    for (int i = 0; i <= 20; i++) cyc(1, 3, 0, 0);
    check("hold_count", int'(bus.cmd_count), 4);
    check("hold_ovf",   int'(bus.overflow),  1);

    // Push + pop while full: code change with pop
    cyc(1, 0, 1, 0);
    check("full_pp_count", int'(bus.cmd_count), 4);
    check("full_pp_ovf",   int'(bus.overflow),  1);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0);

    // Enter never repeats
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 30; i++) cyc(1, 4, 0, 0);
    check("enter_count", int'(bus.cmd_count), 1);
    check("enter_cmd",   int'(bus.cmd),       4);
    cyc(0, 0, 1, 0);

    // Code change mid-hold restarts the delay
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 5; i++)  cyc(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 1, 0, 0);
    check("change_count", int'(bus.cmd_count), 3);
    cyc(0, 0, 0, 0);

    // Ignored codes while held
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 12; i++) cyc(1, 6, 0, 0);
    check("ignored_count", int'(bus.cmd_count), 0);
    cyc(1, 2, 0, 0);

    // Reset while holding with three entries stored
    cyc(0, 0, 0, 1);
    for (int i = 0; i <= 12; i++) cyc(1, 1, 0, 0);
    check("pre_rst_count", int'(bus.cmd_count), 3);
    cyc(1, 1, 0, 1);
    check("mid_rst_count", int'(bus.cmd_count), 0);
    check("mid_rst_ovf",   int'(bus.overflow),  0);
    cyc(1, 1, 0, 0);
    check("post_rst_count", int'(bus.cmd_count), 1);
    check("post_rst_cmd",   int'(bus.cmd),       1);

    // Random traffic
    k = 0;
    n = 3'd0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) k = ~k;
      if ($urandom_range(0, 24) == 0) n = 3'($urandom_range(0, 7));
      cyc(k, n, ($urandom_range(0, 3) == 0), ($urandom_range(0, 299) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
